// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one fp adder and one fp multiplier
// between N_REQ requesters; add and mul channels run independently.
module fp_unit_arbiter #(
    parameter int DBL_WIDTH = 64,
    parameter int N_REQ     = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_op,
    input  logic [N_REQ*DBL_WIDTH-1:0] req_a,
    input  logic [N_REQ*DBL_WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           resp_valid,
    output logic [N_REQ*DBL_WIDTH-1:0] resp_data,
    output logic                       add_go,
    output logic [DBL_WIDTH-1:0]       add_a,
    output logic [DBL_WIDTH-1:0]       add_b,
    input  logic                       add_finish,
    input  logic [DBL_WIDTH-1:0]       add_result,
    output logic                       mul_go,
    output logic [DBL_WIDTH-1:0]       mul_a,
    output logic [DBL_WIDTH-1:0]       mul_b,
    input  logic                       mul_finish,
    input  logic [DBL_WIDTH-1:0]       mul_result,
    output logic [1:0]                 timeout_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q [2];
    logic [IW-1:0]        owner_q [2];
    logic [IW-1:0]        ptr_q   [2];
    logic [IW-1:0]        gnt_idx [2];
    logic [CW-1:0]        cnt_q   [2];
    logic [DBL_WIDTH-1:0] opa_q   [2];
    logic [DBL_WIDTH-1:0] opb_q   [2];
    logic [DBL_WIDTH-1:0] res     [2];
    logic [1:0]           go_q;
    logic [1:0]           fin;
    logic [1:0]           gnt_v;
    logic [N_REQ-1:0]     busy;

    assign fin    = {mul_finish, add_finish};
    assign res[0] = add_result;
    assign res[1] = mul_result;
    assign add_go = go_q[0];
    assign mul_go = go_q[1];
    assign add_a  = opa_q[0];
    assign add_b  = opb_q[0];
    assign mul_a  = opa_q[1];
    assign mul_b  = opb_q[1];

    // A requester owning an op on either channel is not eligible anywhere
    always_comb begin
        busy = '0;
        for (int c = 0; c < 2; c++) begin
            if (state_q[c] != IDLE) busy[owner_q[c]] = 1'b1;
        end
    end

    // Descending scan so the closest index at/after the pointer wins
    always_comb begin
        logic [IW-1:0] ii;
        int            idx;
        gnt_v = '0;
        ii    = '0;
        idx   = 0;
        for (int c = 0; c < 2; c++) begin
            gnt_idx[c] = '0;
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx = int'(ptr_q[c]) + k;
                if (idx >= N_REQ) idx = idx - N_REQ;
                ii = IW'(idx);
                if (state_q[c] == IDLE && req_valid[ii] &&
                    req_op[ii] == c[0] && !busy[ii]) begin
                    gnt_v[c]   = 1'b1;
                    gnt_idx[c] = ii;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int c = 0; c < 2; c++) begin
            if (gnt_v[c]) req_ready[gnt_idx[c]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= IDLE;
                owner_q[c] <= '0;
                ptr_q[c]   <= '0;
                cnt_q[c]   <= '0;
                opa_q[c]   <= '0;
                opb_q[c]   <= '0;
            end
            go_q        <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            timeout_err <= '0;
        end else begin
            go_q       <= '0;
            resp_valid <= '0;
            for (int c = 0; c < 2; c++) begin
                unique case (state_q[c])
                    IDLE: begin
                        if (gnt_v[c]) begin
                            opa_q[c]   <= req_a[gnt_idx[c]*DBL_WIDTH +: DBL_WIDTH];
                            opb_q[c]   <= req_b[gnt_idx[c]*DBL_WIDTH +: DBL_WIDTH];
                            owner_q[c] <= gnt_idx[c];
                            ptr_q[c]   <= (gnt_idx[c] == IW'(N_REQ - 1)) ?
                                          '0 : gnt_idx[c] + IW'(1);
                            go_q[c]    <= 1'b1;
                            state_q[c] <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        cnt_q[c]   <= '0;
                        state_q[c] <= WAIT;
                    end
                    WAIT: begin
                        if (fin[c]) begin
                            resp_data[owner_q[c]*DBL_WIDTH +: DBL_WIDTH] <= res[c];
                            resp_valid[owner_q[c]] <= 1'b1;
                            state_q[c] <= RESP;
                        end else if (cnt_q[c] == CW'(TIMEOUT - 1)) begin
                            // Abort: answer the owner with zero so it never stalls
                            resp_data[owner_q[c]*DBL_WIDTH +: DBL_WIDTH] <= '0;
                            resp_valid[owner_q[c]] <= 1'b1;
                            timeout_err[c] <= 1'b1;
                            state_q[c]     <= RESP;
                        end else begin
                            cnt_q[c] <= cnt_q[c] + 1'b1;
                        end
                    end
                    RESP: state_q[c] <= IDLE;
                    default: state_q[c] <= IDLE;
                endcase
            end
        end
    end

endmodule
